mem_rmw_unit: RTL and testbench
===============================

MEM_RMW_UNIT -- requirements
Module: mem_rmw_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the 64-bit-word address width of the data memory.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  ADDR_W  word address.
REQ-008 SHALL have port req_mask  input  64  byte-granular bit mask from the 64-bit byte masker; each byte is 0x00 or 0xFF.
REQ-009 SHALL have port req_wdata  input  64  store data.
REQ-010 SHALL have port req_signed  input  1  load sign-extension request, honoured only per REQ-031.
REQ-011 SHALL have port mem_en, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  64; mem_rdata  input  64  single-port synchronous RAM, read data valid the cycle after mem_en=1 with mem_we=0.
REQ-012 SHALL have port resp_valid  output  1 and resp_rdata  output  64  completion pulse and load result.

Function
REQ-013 SHALL implement FSM states IDLE, READ, MERGE, WRITE, RESP.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1; all request fields are latched on acceptance.
REQ-015 SHALL go IDLE->READ on accepting a load or a store whose mask is neither all-ones nor all-zeros.
REQ-016 SHALL go IDLE->WRITE on accepting a store with mask all-ones (no read issued).
REQ-017 SHALL go IDLE->RESP on accepting a store with mask all-zeros (no memory access).
REQ-018 SHALL in READ drive mem_en=1, mem_we=0, mem_addr=latched address, then go to MERGE.
REQ-019 SHALL in MERGE for a load capture resp_rdata = mem_rdata AND mask (then REQ-031), drive no memory access, and go to RESP.
REQ-020 SHALL in MERGE for a store drive mem_en=1, mem_we=1, mem_wdata = (mem_rdata AND NOT mask) OR (wdata AND mask), then go to RESP.
REQ-021 SHALL in WRITE drive mem_en=1, mem_we=1, mem_wdata=latched wdata, then go to RESP.
REQ-022 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE; resp_valid has no back-pressure.
REQ-023 SHALL give accept-to-resp_valid latency of 3 cycles for loads and partial stores, 2 for full stores, and 1 for zero-mask stores.
REQ-024 SHALL hold resp_rdata stable from RESP until the next load's MERGE; stores leave resp_rdata unchanged.
REQ-025 SHALL return resp_rdata=0 for a load with mask all-zeros, performing the read anyway.
REQ-026 SHALL drive mem_en=0 and mem_we=0 in IDLE and RESP.
REQ-027 SHALL ignore req_valid while not in IDLE; a request held across busy cycles is accepted on the next IDLE cycle.

Reset
REQ-028 SHALL on a rising edge with rst=1 set state=IDLE, resp_valid=0, resp_rdata=0, and clear all latched request fields.
REQ-029 SHALL force mem_en=0 and mem_we=0 combinationally whenever rst=1, so a reset mid-operation never produces a memory write.
REQ-030 SHALL drop any in-flight request on reset, with no response issued for it.

Configuration
REQ-031 SHALL, with macro MEM_RMW_SIGN_EXT_EN defined and req_signed=1 on a load, replace every result bit above the highest set mask bit with that bit's value; without the macro, or with req_signed=0, loads SHALL zero-extend and req_signed SHALL be unused.

Verification
REQ-032 Load: mem[5]=0x1122_3344_8899_AABB, addr 5, mask 0x0000_0000_0000_FFFF -> resp_valid 3 cycles after accept, resp_rdata=0x0000_0000_0000_AABB; with macro and req_signed=1 -> 0xFFFF_FFFF_FFFF_AABB.
REQ-033 Partial store: mem[2]=0xFFFF_FFFF_FFFF_FFFF, wdata=0x0123_4567_89AB_CDEF, mask 0x0000_0000_FFFF_FFFF -> one write in cycle 2 with mem_wdata=0xFFFF_FFFF_89AB_CDEF, resp_valid at cycle 3.
REQ-034 Full store: mask all-ones, wdata 0xDEAD_BEEF_0000_0001 -> no read cycle, write in cycle 1, resp_valid at cycle 2; zero-mask store -> no mem_en at all, resp_valid at cycle 1.
REQ-035 Back-to-back: req_valid held high for two loads -> req_ready low for 3 cycles after the first accept, second accepted in the IDLE cycle after RESP, two distinct resp_valid pulses.
REQ-036 Reset in MERGE of a partial store -> mem_we=0 during the rst cycle, memory unchanged, state IDLE, resp_valid never asserted for that request.

Source files
------------

// File: rtl/mem_rmw_unit.sv
// mem_rmw_unit: byte-masked load / read-modify-write store unit in front of a
// single-port synchronous 64-bit RAM.
//   Loads          : READ -> MERGE -> RESP  (result = rdata AND mask)
//   Partial stores : READ -> MERGE (merged write) -> RESP
//   Full stores    : WRITE -> RESP  (no read)
//   Zero stores    : RESP           (no memory access)
// Optional feature macro: MEM_RMW_SIGN_EXT_EN. When it is defined, a load with
// req_signed=1 copies the highest selected bit into every result bit above it.
module mem_rmw_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_mask,
  input  logic [63:0]       req_wdata,
  input  logic              req_signed,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Request fields captured on acceptance
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [63:0]       mask_reg;
  logic [63:0]       wdata_reg;
  logic [63:0]       resp_rdata_reg;

  logic        accept;
  logic        mask_full;
  logic        mask_zero;
  logic        mem_en_raw;
  logic        mem_we_raw;
  logic [63:0] merged_data;
  logic [63:0] masked_rdata;
  logic [63:0] load_result;

  assign accept    = req_valid && (state_reg == IDLE);
  assign mask_full = &req_mask;
  assign mask_zero = ~|req_mask;

  // Byte lanes: the mask is byte-granular, so merging works lane by lane
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign merged_data[gi*8 +: 8]  = (mem_rdata[gi*8 +: 8] & ~mask_reg[gi*8 +: 8])
                                   | (wdata_reg[gi*8 +: 8] &  mask_reg[gi*8 +: 8]);
    assign masked_rdata[gi*8 +: 8] = mem_rdata[gi*8 +: 8] & mask_reg[gi*8 +: 8];
  end

`ifdef MEM_RMW_SIGN_EXT_EN
  logic signed_reg;
  logic sign_bit;
  logic above_top;

  // Sign extension: replicate the highest selected bit into all bits above it
  always_comb begin
    sign_bit    = 1'b0;
    above_top   = 1'b1;
    load_result = masked_rdata;
    for (int i = 0; i < 64; i++) begin
      if (mask_reg[i]) sign_bit = masked_rdata[i];
    end
    for (int i = 63; i >= 0; i--) begin
      if (mask_reg[i]) above_top = 1'b0;
      if (above_top && signed_reg) load_result[i] = sign_bit;
    end
  end
`else
  // Without sign extension, loads are always zero-extended
  logic unused_signed;
  assign unused_signed = req_signed;
  assign load_result   = masked_rdata;
`endif

  // Next-state and output decode
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_en_raw = 1'b0;
    mem_we_raw = 1'b0;
    mem_wdata  = 64'd0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_we)        state_next = READ;
          else if (mask_full) state_next = WRITE;
          else if (mask_zero) state_next = RESP;
          else                state_next = READ;
        end
      end
      READ: begin
        mem_en_raw = 1'b1;
        state_next = MERGE;
      end
      MERGE: begin
        if (we_reg) begin
          mem_en_raw = 1'b1;
          mem_we_raw = 1'b1;
          mem_wdata  = merged_data;
        end
        state_next = RESP;
      end
      WRITE: begin
        mem_en_raw = 1'b1;
        mem_we_raw = 1'b1;
        mem_wdata  = wdata_reg;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset gates the RAM strobes directly so an interrupted RMW never writes
  assign mem_en     = mem_en_raw & ~rst;
  assign mem_we     = mem_we_raw & ~rst;
  assign mem_addr   = addr_reg;
  assign resp_rdata = resp_rdata_reg;

  // State, request latch and load-result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      mask_reg       <= 64'd0;
      wdata_reg      <= 64'd0;
      resp_rdata_reg <= 64'd0;
`ifdef MEM_RMW_SIGN_EXT_EN
      signed_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        mask_reg  <= req_mask;
        wdata_reg <= req_wdata;
`ifdef MEM_RMW_SIGN_EXT_EN
        signed_reg <= req_signed;
`endif
      end
      if (state_reg == MERGE && !we_reg) resp_rdata_reg <= load_result;
    end
  end

endmodule

// File: tb/tb_mem_rmw_unit.sv
// Directed testbench for mem_rmw_unit with a behavioural synchronous RAM.
module tb_mem_rmw_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_mask;
  logic [63:0]       req_wdata;
  logic              req_signed;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;

  // RAM model plus a preload port used only during reset
  logic [63:0]       ram [0:1023];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [63:0]       pl_data = 64'd0;

  always #5 clk = ~clk;

  mem_rmw_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .req_signed (req_signed),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and observe it until resp_valid (bounded)
  task automatic run_req(input logic we, input logic [ADDR_W-1:0] a, input logic [63:0] m,
                         input logic [63:0] wd, input logic sg,
                         output int lat, output int rcyc, output int wcyc, output int nen);
    lat = -1; rcyc = -1; wcyc = -1; nen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_mask = m; req_wdata = wd; req_signed = sg;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_en) nen++;
      if (mem_en && !mem_we) rcyc = c;
      if (mem_en && mem_we) wcyc = c;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    $display("txn we=%0b addr=%0d mask=%h lat=%0d rd=%h", we, a, m, lat, resp_rdata);
  endtask

  int lat, rcyc, wcyc, nen;
  logic [63:0] exp_signed;
  logic        busy_ready;
  int          p1, p2, npulse;
  logic [63:0] r1, r2;
  int          cnt_before;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_mask = 64'd0; req_wdata = 64'd0; req_signed = 1'b0;
`ifdef MEM_RMW_SIGN_EXT_EN
    exp_signed = 64'hFFFF_FFFF_FFFF_AABB;
`else
    exp_signed = 64'h0000_0000_0000_AABB;
`endif

    preload(10'd5, 64'h1122_3344_8899_AABB);
    preload(10'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    preload(10'd7, 64'd0);
    preload(10'd8, 64'h5555_6666_7777_8888);
    preload(10'd9, 64'd0);
    @(negedge clk);
    chk("reset_ready",      64'(req_ready),  64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_resp_rdata", resp_rdata,      64'd0);
    chk("reset_mem_en",     64'(mem_en),     64'd0);
    rst = 1'b0;

    // Unsigned load
    run_req(1'b0, 10'd5, 64'h0000_0000_0000_FFFF, 64'd0, 1'b0, lat, rcyc, wcyc, nen);
    chk("load_lat",   64'(lat),  64'd3);
    chk("load_rdata", resp_rdata, 64'h0000_0000_0000_AABB);
    chk("load_rcyc",  64'(rcyc), 64'd1);
    chk("load_nen",   64'(nen),  64'd1);

    // Signed load (extends only when the feature is built in)
    run_req(1'b0, 10'd5, 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, lat, rcyc, wcyc, nen);
    chk("sload_rdata", resp_rdata, exp_signed);

    // Partial store
    run_req(1'b1, 10'd2, 64'h0000_0000_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0, lat, rcyc, wcyc, nen);
    chk("pst_lat",   64'(lat),  64'd3);
    chk("pst_wcyc",  64'(wcyc), 64'd2);
    chk("pst_nen",   64'(nen),  64'd2);
    chk("pst_mem",   ram[2],    64'hFFFF_FFFF_89AB_CDEF);
    chk("pst_rdata_hold", resp_rdata, exp_signed);

    // Full store
    run_req(1'b1, 10'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001, 1'b0, lat, rcyc, wcyc, nen);
    chk("fst_lat",  64'(lat),  64'd2);
    chk("fst_wcyc", 64'(wcyc), 64'd1);
    chk("fst_nen",  64'(nen),  64'd1);
    chk("fst_mem",  ram[7],    64'hDEAD_BEEF_0000_0001);

    // Zero-mask store
    run_req(1'b1, 10'd8, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, rcyc, wcyc, nen);
    chk("zst_lat", 64'(lat), 64'd1);
    chk("zst_nen", 64'(nen), 64'd0);
    chk("zst_mem", ram[8],   64'h5555_6666_7777_8888);

    // Zero-mask load still reads, returns zero
    run_req(1'b0, 10'd5, 64'd0, 64'd0, 1'b1, lat, rcyc, wcyc, nen);
    chk("zld_lat",   64'(lat),  64'd3);
    chk("zld_nen",   64'(nen),  64'd1);
    chk("zld_rdata", resp_rdata, 64'd0);

    // Top byte selected: nothing above to extend
    run_req(1'b0, 10'd2, 64'hFF00_0000_0000_0000, 64'd0, 1'b1, lat, rcyc, wcyc, nen);
    chk("topld_rdata", resp_rdata, 64'hFF00_0000_0000_0000);

    // Back-to-back loads with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    req_mask = 64'h0000_0000_0000_FFFF; req_signed = 1'b0;
    @(posedge clk);
    #1 req_addr = 10'd7; req_mask = 64'h0000_0000_FFFF_FFFF;
    busy_ready = 1'b0; p1 = -1; p2 = -1; npulse = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 3 && req_ready) busy_ready = 1'b1;
      if (c == 4) chk("b2b_ready_idle", 64'(req_ready), 64'd1);
      if (c == 5) req_valid = 1'b0;
      if (resp_valid) begin
        npulse++;
        if (npulse == 1) begin p1 = c; r1 = resp_rdata; end
        else             begin p2 = c; r2 = resp_rdata; end
      end
    end
    $display("txn b2b pulses=%0d p1=%0d p2=%0d", npulse, p1, p2);
    chk("b2b_busy_ready", 64'(busy_ready), 64'd0);
    chk("b2b_npulse", 64'(npulse), 64'd2);
    chk("b2b_p1",     64'(p1),     64'd3);
    chk("b2b_p2",     64'(p2),     64'd7);
    chk("b2b_r1",     r1,          64'h0000_0000_0000_AABB);
    chk("b2b_r2",     r2,          64'h0000_0000_0000_0001);

    // Reset during MERGE of a partial store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd9;
    req_mask = 64'h0000_0000_0000_00FF; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cnt_before = resp_cnt;
    @(negedge clk);
    @(negedge clk);
    chk("rstm_we_pre", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstm_we", 64'(mem_we), 64'd0);
    chk("rstm_en", 64'(mem_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_ready", 64'(req_ready), 64'd1);
    chk("rstm_rdata", resp_rdata,     64'd0);
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("rstm_noresp", 64'(resp_cnt), 64'(cnt_before));
    chk("rstm_mem",    ram[9],        64'd0);
    $display("txn reset-in-merge resp_cnt=%0d mem9=%h", resp_cnt, ram[9]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
